// File: rtl/bmp280_sample_store.sv
// Avalon-MM slave buffering BMP280 raw sample writes in a word FIFO and
// presenting them to a downstream consumer on a valid/ready stream.
`timescale 1ns/1ps
module bmp280_sample_store #(
    parameter int DEPTH = 16,
    parameter int LVL_W = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] address,
    input  logic        read,
    output logic [31:0] readdata,
    output logic        readdatavalid,
    output logic        waitrequest,
    input  logic        write,
    input  logic [3:0]  byteenable,
    input  logic [31:0] writedata,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]      mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LVL_W-1:0] level;
    logic             enable;
    logic [7:0]       err_cnt;
    logic [7:0]       drop_cnt;

    logic [1:0]  reg_sel;
    logic        data_wr, be_ok, full, empty;
    logic        push, pop, flush, ctrl_wr;
    logic        data_drop, data_bad, rsvd_wr, rd_ok, rd_conflict;
    logic [1:0]  err_inc;
    logic [31:0] status_word;
    logic [31:0] read_mux;
    logic        unused_addr;

    function automatic logic [7:0] sat_add(input logic [7:0] cnt, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, cnt} + {7'b0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    assign reg_sel     = address[3:2];
    assign unused_addr = ^{address[31:4], address[1:0]};

    assign data_wr   = write && (reg_sel == 2'd0);
    assign be_ok     = (byteenable == 4'hF);
    assign full      = (level == LVL_W'(DEPTH));
    assign empty     = (level == '0);

    // Full comes from the registered level, so a same-cycle pop cannot unstall a push.
    assign waitrequest = data_wr && be_ok && enable && full;
    assign push        = data_wr && be_ok && enable && !full;
    assign data_drop   = data_wr && be_ok && !enable;
    assign data_bad    = data_wr && !be_ok;
    assign ctrl_wr     = write && (reg_sel == 2'd2) && byteenable[0];
    assign flush       = ctrl_wr && writedata[0];
    assign rsvd_wr     = write && (reg_sel == 2'd3);
    assign rd_ok       = read && !write;
    assign rd_conflict = read && write;
    assign err_inc     = 2'(data_bad) + 2'(rsvd_wr) + 2'(rd_conflict);

    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_comb begin
        status_word              = '0;
        status_word[LVL_W-1:0]   = level;
        status_word[8]           = empty;
        status_word[9]           = full;
        status_word[10]          = enable;
        status_word[23:16]       = err_cnt;
        status_word[31:24]       = drop_cnt;
    end

    always_comb begin
        read_mux = '0;
        case (reg_sel)
            2'd1:    read_mux = status_word;
            2'd2:    read_mux = {30'b0, enable, 1'b0};
            default: read_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= writedata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level         <= '0;
            enable        <= 1'b1;
            err_cnt       <= '0;
            drop_cnt      <= '0;
            readdata      <= '0;
            readdatavalid <= 1'b0;
        end else begin
            readdatavalid <= rd_ok;
            if (rd_ok) readdata <= read_mux;
            if (ctrl_wr) enable <= writedata[1];
            err_cnt  <= sat_add(err_cnt, err_inc);
            drop_cnt <= sat_add(drop_cnt, {1'b0, data_drop});
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                level <= level + LVL_W'(push) - LVL_W'(pop);
            end
        end
    end

endmodule

// File: tb/tb_bmp280_sample_store.sv
// Randomized and directed bench for bmp280_sample_store against a queue-based model.
`timescale 1ns/1ps
module tb_bmp280_sample_store;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] address = '0;
    logic        read = 1'b0;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic        waitrequest;
    logic        write = 1'b0;
    logic [3:0]  byteenable = 4'hF;
    logic [31:0] writedata = '0;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_q[$];
    logic        m_en = 1'b1;
    int          m_err = 0;
    int          m_drop = 0;
    logic        m_rdv = 1'b0;
    logic [31:0] m_rd = '0;

    bmp280_sample_store #(.DEPTH(DEPTH), .LVL_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .address(address), .read(read),
        .readdata(readdata), .readdatavalid(readdatavalid), .waitrequest(waitrequest),
        .write(write), .byteenable(byteenable), .writedata(writedata),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] m_status();
        int n;
        n = m_q.size();
        return {m_drop[7:0], m_err[7:0], 5'b0, m_en, (n == DEPTH), (n == 0), 3'b0, 5'(n)};
    endfunction

    function automatic logic m_wait();
        return write && (address[3:2] == 2'd0) && (byteenable == 4'hF) && m_en && (m_q.size() == DEPTH);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_en = 1'b1; m_err = 0; m_drop = 0; m_rdv = 1'b0; m_rd = '0;
    endtask

    // Evaluate one clock of bus/stream activity in the model, then advance the DUT.
    task automatic step();
        logic        push, flush, pop, nen, rd_take;
        logic [31:0] rv, wd, dummy;
        int          einc, dinc;
        push = 1'b0; flush = 1'b0; nen = m_en; einc = 0; dinc = 0; wd = writedata;
        pop = (m_q.size() != 0) && out_ready;
        if (write) begin
            case (address[3:2])
                2'd0: begin
                    if (byteenable != 4'hF) einc++;
                    else if (!m_en) dinc++;
                    else if (m_q.size() < DEPTH) push = 1'b1;
                end
                2'd2: if (byteenable[0]) begin flush = writedata[0]; nen = writedata[1]; end
                2'd3: einc++;
                default: ;
            endcase
        end
        if (read && write) einc++;
        rd_take = read && !write;
        case (address[3:2])
            2'd1:    rv = m_status();
            2'd2:    rv = {30'b0, m_en, 1'b0};
            default: rv = '0;
        endcase
        @(posedge clk); #1;
        m_rdv = rd_take;
        if (rd_take) m_rd = rv;
        if (flush) m_q.delete();
        else begin
            if (pop) dummy = m_q.pop_front();
            if (push) m_q.push_back(wd);
        end
        m_en = nen;
        m_err = (m_err + einc > 255) ? 255 : m_err + einc;
        m_drop = (m_drop + dinc > 255) ? 255 : m_drop + dinc;
    endtask

    task automatic idle();
        write = 1'b0; read = 1'b0; out_ready = 1'b0;
        address = '0; byteenable = 4'hF; writedata = '0;
    endtask

    task automatic do_reset();
        idle();
        @(posedge clk); #1;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        address = a; writedata = d; byteenable = be; write = 1'b1;
        step();
        write = 1'b0; byteenable = 4'hF;
    endtask

    task automatic bus_read(input logic [31:0] a);
        address = a; read = 1'b1;
        step();
        read = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata got %h required %h", readdata, 32'h0); end
        checks++; if (readdatavalid !== 1'b0) begin errors++; $display("FAIL reset_rdv got %b required 0", readdatavalid); end
        checks++; if (waitrequest !== 1'b0) begin errors++; $display("FAIL reset_wait got %b required 0", waitrequest); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b required 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h required 0", out_data); end
        bus_read(32'h4);
        checks++; if (readdatavalid !== 1'b1 || readdata !== 32'h0000_0500) begin
            errors++; $display("FAIL reset_status got rdv=%b %h required rdv=1 %h", readdatavalid, readdata, 32'h500); end
        step();
        checks++; if (readdatavalid !== 1'b0) begin errors++; $display("FAIL rdv_one_cycle got %b required 0", readdatavalid); end
    endtask

    task automatic test_single_push();
        do_reset();
        bus_write(32'h0, 32'h00AB_CDEF, 4'hF);
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h00AB_CDEF) begin
            errors++; $display("FAIL single_push got v=%b %h required v=1 %h", out_valid, out_data, 32'h00AB_CDEF); end
        bus_read(32'h4);
        checks++; if (readdata[4:0] !== 5'd1 || readdata !== m_rd) begin
            errors++; $display("FAIL single_level got %h required %h", readdata, m_rd); end
    endtask

    task automatic test_full_backpressure();
        do_reset();
        for (int i = 1; i <= 16; i++) bus_write(32'h0, i, 4'hF);
        address = 32'h0; writedata = 32'd17; byteenable = 4'hF; write = 1'b1;
        #1;
        checks++; if (waitrequest !== 1'b1) begin errors++; $display("FAIL full_wait got %b required 1", waitrequest); end
        step();
        out_ready = 1'b1; #1;
        checks++; if (waitrequest !== 1'b1) begin errors++; $display("FAIL full_wait_pop_cycle got %b required 1", waitrequest); end
        checks++; if (out_data !== 32'd1) begin errors++; $display("FAIL full_head got %h required 1", out_data); end
        step();
        out_ready = 1'b0; #1;
        checks++; if (waitrequest !== 1'b0) begin errors++; $display("FAIL full_release got %b required 0", waitrequest); end
        step();
        write = 1'b0;
        bus_read(32'h4);
        checks++; if (readdata[9] !== 1'b1 || readdata[4:0] !== 5'd16) begin
            errors++; $display("FAIL full_status got %h required level 16 full 1", readdata); end
        out_ready = 1'b1;
        for (int k = 2; k <= 17; k++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== k) begin
                errors++; $display("FAIL drain_order got v=%b %h required v=1 %h", out_valid, out_data, k); end
            step();
        end
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %b required 0", out_valid); end
    endtask

    task automatic test_errors();
        do_reset();
        bus_write(32'h0, 32'h1234_5678, 4'h3);
        bus_write(32'hC, 32'hFFFF_FFFF, 4'hF);
        bus_read(32'h4);
        checks++; if (readdata[23:16] !== 8'd2 || readdata[4:0] !== 5'd0) begin
            errors++; $display("FAIL err_cnt got %h required err 2 level 0", readdata); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL err_nopush got %b required 0", out_valid); end
    endtask

    task automatic test_drop();
        do_reset();
        bus_write(32'h8, 32'h0, 4'hF);
        for (int i = 0; i < 3; i++) bus_write(32'h0, 32'hA0 + i, 4'hF);
        bus_read(32'h4);
        checks++; if (readdata[31:24] !== 8'd3 || readdata[10] !== 1'b0 || readdata[4:0] !== 5'd0) begin
            errors++; $display("FAIL drop_cnt got %h required drop 3 en 0 level 0", readdata); end
        bus_write(32'h8, 32'h2, 4'hF);
        bus_write(32'h0, 32'h55, 4'hF);
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h55) begin
            errors++; $display("FAIL drop_restore got v=%b %h required v=1 55", out_valid, out_data); end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 5; i++) bus_write(32'h0, 32'h100 + i, 4'hF);
        out_ready = 1'b1;
        bus_write(32'h8, 32'h3, 4'hF);
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b required 0", out_valid); end
        bus_read(32'h4);
        checks++; if (readdata !== 32'h0000_0500) begin errors++; $display("FAIL flush_status got %h required %h", readdata, 32'h500); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs[4];
        do_reset();
        addrs = '{32'h4, 32'h8, 32'hC, 32'h0};
        bus_write(32'h0, 32'hBEEF, 4'hF);
        read = 1'b1;
        for (int i = 0; i < 4; i++) begin
            address = addrs[i];
            step();
            checks++; if (readdatavalid !== 1'b1 || readdata !== m_rd) begin
                errors++; $display("FAIL b2b_read got rdv=%b %h required rdv=1 %h", readdatavalid, readdata, m_rd); end
        end
        read = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 32'hBEEF) begin
            errors++; $display("FAIL data_read_nopop got v=%b %h required v=1 beef", out_valid, out_data); end
        read = 1'b1;
        bus_write(32'h0, 32'hCAFE, 4'hF);
        read = 1'b0;
        checks++; if (readdatavalid !== 1'b0) begin errors++; $display("FAIL rw_conflict_rdv got %b required 0", readdatavalid); end
        bus_read(32'h4);
        checks++; if (readdata[23:16] !== 8'd1 || readdata[4:0] !== 5'd2) begin
            errors++; $display("FAIL rw_conflict_status got %h required err 1 level 2", readdata); end
    endtask

    task automatic test_saturation();
        do_reset();
        bus_write(32'h8, 32'h0, 4'hF);
        for (int i = 0; i < 260; i++) bus_write(32'h0, i, 4'hF);
        for (int i = 0; i < 260; i++) bus_write(32'hC, i, 4'hF);
        bus_read(32'h4);
        checks++; if (readdata[31:24] !== 8'hFF || readdata[23:16] !== 8'hFF) begin
            errors++; $display("FAIL saturation got %h required drop ff err ff", readdata); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < DEPTH; i++) bus_write(32'h0, 32'h200 + i, 4'hF);
        bus_read(32'h4);
        address = 32'h0; writedata = 32'h999; write = 1'b1;
        #1;
        checks++; if (waitrequest !== 1'b1 || readdatavalid !== 1'b1) begin
            errors++; $display("FAIL mid_pre got wait=%b rdv=%b required 1 1", waitrequest, readdatavalid); end
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (waitrequest !== 1'b0 || readdatavalid !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL mid_reset got wait=%b rdv=%b v=%b required 0 0 0", waitrequest, readdatavalid, out_valid); end
        idle();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            logic [1:0] sel;
            write = ($urandom_range(0, 2) == 0);
            read  = write ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 9))
                0: sel = 2'd1;
                1: sel = 2'd2;
                2: sel = 2'd3;
                default: sel = 2'd0;
            endcase
            address = {28'($urandom), sel, 2'($urandom)};
            byteenable = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
            if (sel == 2'd2) writedata = {30'($urandom), ($urandom_range(0, 5) != 0), ($urandom_range(0, 7) == 0)};
            else writedata = $urandom;
            out_ready = ($urandom_range(0, 9) < 3);
            #1;
            checks++; if (waitrequest !== m_wait()) begin
                errors++; $display("FAIL rand_wait cyc %0d got %b required %b", c, waitrequest, m_wait()); end
            step();
            checks++; if (out_valid !== (m_q.size() != 0)) begin
                errors++; $display("FAIL rand_valid cyc %0d got %b required %b", c, out_valid, m_q.size() != 0); end
            if (m_q.size() != 0) begin
                checks++; if (out_data !== m_q[0]) begin
                    errors++; $display("FAIL rand_data cyc %0d got %h required %h", c, out_data, m_q[0]); end
            end
            checks++; if (readdatavalid !== m_rdv) begin
                errors++; $display("FAIL rand_rdv cyc %0d got %b required %b", c, readdatavalid, m_rdv); end
            if (m_rdv) begin
                checks++; if (readdata !== m_rd) begin
                    errors++; $display("FAIL rand_rdata cyc %0d got %h required %h", c, readdata, m_rd); end
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_full_backpressure();
        test_errors();
        test_drop();
        test_flush();
        test_back_to_back();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
